// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    // 0 = CPU datapath, 1 = debug/program loader
    typedef logic port_id_t;

    localparam port_id_t PORT_CPU    = 1'b0;
    localparam port_id_t PORT_LOADER = 1'b1;

    localparam int MEM_ADDR_W = 20;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side handshake bundle for both arbiter ports
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata
    );
endinterface

// File: rtl/sram_arb_select.sv
// rtl/sram_arb_select.sv - combinational winner pick; SRAM_ARB_CPU_PRIORITY_EN selects fixed CPU priority
module sram_arb_select
    import sram_arb_pkg::*;
(
    input  logic     p0_req,
    input  logic     p1_req,
    input  port_id_t last_grant,
    output logic     grant_valid,
    output port_id_t grant
);

`ifdef SRAM_ARB_CPU_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant_valid = p0_req | p1_req;
        grant       = PORT_CPU;
        if (p0_req && p1_req) begin
`ifdef SRAM_ARB_CPU_PRIORITY_EN
            grant = PORT_CPU;
`else
            grant = ~last_grant;
`endif
        end else if (p1_req) begin
            grant = PORT_LOADER;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port async SRAM arbiter with fixed-length strobe sequencing
// Build option: SRAM_ARB_CPU_PRIORITY_EN (see sram_arb_select)
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sram_arbiter_if.slave         req_bus,
    output logic [MEM_ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0]     Mem_DQ_out,
    output logic                  Mem_DQ_oe,
    input  logic [DATA_W-1:0]     Mem_DQ_in,
    output logic                  Mem_CE,
    output logic                  Mem_UB,
    output logic                  Mem_LB,
    output logic                  Mem_OE,
    output logic                  Mem_WE,
    output logic                  busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    arb_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              last_cycle;

    port_id_t          last_grant;
    port_id_t          grant;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;
    logic [MEM_ADDR_W-1:0] mem_addr_q;

    logic              sel_valid;
    port_id_t          sel_grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    sram_arb_select u_select (
        .p0_req      (req_bus.p0_req),
        .p1_req      (req_bus.p1_req),
        .last_grant  (last_grant),
        .grant_valid (sel_valid),
        .grant       (sel_grant)
    );

    assign sel_we    = sel_grant ? req_bus.p1_we    : req_bus.p0_we;
    assign sel_addr  = sel_grant ? req_bus.p1_addr  : req_bus.p0_addr;
    assign sel_wdata = sel_grant ? req_bus.p1_wdata : req_bus.p0_wdata;

    assign last_cycle = (cnt == CNT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_next = ACCESS;
                    cnt_next   = '0;
                end
            end
            ACCESS: begin
                if (last_cycle) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Payload is captured only at grant so requester changes mid-access are ignored
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            last_grant <= PORT_LOADER;
            grant      <= PORT_CPU;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            mem_addr_q <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            if (state == IDLE && sel_valid) begin
                grant      <= sel_grant;
                last_grant <= sel_grant;
                lat_we     <= sel_we;
                lat_wdata  <= sel_wdata;
                mem_addr_q <= MEM_ADDR_W'(sel_addr);
            end
            if (state == ACCESS && last_cycle && !lat_we) begin
                if (grant == PORT_CPU) begin
                    p0_rdata_q <= Mem_DQ_in;
                end else begin
                    p1_rdata_q <= Mem_DQ_in;
                end
            end
        end
    end

    always_comb begin
        Mem_CE         = 1'b1;
        Mem_UB         = 1'b1;
        Mem_LB         = 1'b1;
        Mem_OE         = 1'b1;
        Mem_WE         = 1'b1;
        Mem_DQ_oe      = 1'b0;
        req_bus.p0_ack = 1'b0;
        req_bus.p1_ack = 1'b0;
        case (state)
            ACCESS: begin
                Mem_CE = 1'b0;
                Mem_UB = 1'b0;
                Mem_LB = 1'b0;
                if (lat_we) begin
                    Mem_WE    = 1'b0;
                    Mem_DQ_oe = 1'b1;
                end else begin
                    Mem_OE = 1'b0;
                end
            end
            DONE: begin
                req_bus.p0_ack = (grant == PORT_CPU);
                req_bus.p1_ack = (grant == PORT_LOADER);
            end
            default: ;
        endcase
    end

    assign busy             = (state != IDLE);
    assign Mem_ADDR         = mem_addr_q;
    assign Mem_DQ_out       = lat_wdata;
    assign req_bus.p0_rdata = p0_rdata_q;
    assign req_bus.p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [19:0] Mem_ADDR;
    logic [15:0] Mem_DQ_out;
    logic        Mem_DQ_oe;
    logic [15:0] Mem_DQ_in;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_bus    (bus.slave),
        .Mem_ADDR   (Mem_ADDR),
        .Mem_DQ_out (Mem_DQ_out),
        .Mem_DQ_oe  (Mem_DQ_oe),
        .Mem_DQ_in  (Mem_DQ_in),
        .Mem_CE     (Mem_CE),
        .Mem_UB     (Mem_UB),
        .Mem_LB     (Mem_LB),
        .Mem_OE     (Mem_OE),
        .Mem_WE     (Mem_WE),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    function automatic logic [4:0] strobes();
        return {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
    endfunction

    initial begin
        int oe_low, we_low, dqoe_hi, ack0, ack1, nacks, waited;
        logic [3:0] grants;
        logic [3:0] exp_grants;

        Reset = 1'b0;
        Mem_DQ_in = 16'h0000;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;

        // 1. reset
        cyc(); cyc();
        Reset = 1'b1;
        check("rst_strobes", 32'(strobes()), 32'h1F);
        check("rst_acks", {30'd0, bus.p0_ack, bus.p1_ack}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dqoe", 32'(Mem_DQ_oe), 32'd0);
        check("rst_addr", 32'(Mem_ADDR), 32'd0);

        // 2. p0 read
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 16'h3000;
        Mem_DQ_in = 16'hBEEF;
        cyc();
        check("rd_c1_oe", 32'(Mem_OE), 32'd0);
        check("rd_c1_ce", 32'(Mem_CE), 32'd0);
        check("rd_c1_we", 32'(Mem_WE), 32'd1);
        check("rd_c1_ack", 32'(bus.p0_ack), 32'd0);
        check("rd_addr", 32'(Mem_ADDR), 32'h03000);
        cyc();
        check("rd_c2_oe", 32'(Mem_OE), 32'd0);
        check("rd_c2_ack", 32'(bus.p0_ack), 32'd0);
        cyc();
        check("rd_c3_ack", 32'(bus.p0_ack), 32'd1);
        check("rd_c3_p1ack", 32'(bus.p1_ack), 32'd0);
        check("rd_c3_rdata", 32'(bus.p0_rdata), 32'hBEEF);
        check("rd_c3_strobes", 32'(strobes()), 32'h1F);
        bus.p0_req = 1'b0;
        cyc();
        check("rd_idle_busy", 32'(busy), 32'd0);
        check("rd_idle_ack", 32'(bus.p0_ack), 32'd0);
        check("rd_idle_addr", 32'(Mem_ADDR), 32'h03000);

        // 3. p1 write
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 16'h0010; bus.p1_wdata = 16'h1234;
        oe_low = 0; we_low = 0; dqoe_hi = 0; ack1 = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (!Mem_OE) oe_low++;
            if (!Mem_WE) begin
                we_low++;
                check("wr_dq_out", 32'(Mem_DQ_out), 32'h1234);
                check("wr_addr", 32'(Mem_ADDR), 32'h00010);
            end
            if (Mem_DQ_oe) dqoe_hi++;
            if (bus.p1_ack) begin
                ack1++;
                bus.p1_req = 1'b0;
            end
        end
        check("wr_we_cycles", 32'(we_low), 32'd2);
        check("wr_dqoe_cycles", 32'(dqoe_hi), 32'd2);
        check("wr_oe_low", 32'(oe_low), 32'd0);
        check("wr_ack_count", 32'(ack1), 32'd1);
        check("wr_p0_rdata_held", 32'(bus.p0_rdata), 32'hBEEF);

        // 4. both requesting continuously; last grant was p1
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 16'h0001;
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 16'h0002;
        Mem_DQ_in = 16'h0F0F;
        grants = '0; nacks = 0; ack0 = 0; ack1 = 0;
        for (int i = 0; i < 40 && nacks < 4; i++) begin
            cyc();
            if (bus.p0_ack && bus.p1_ack) check("rr_dual_ack", 32'd1, 32'd0);
            if (bus.p0_ack) begin ack0++; grants[nacks] = 1'b0; nacks++; end
            else if (bus.p1_ack) begin ack1++; grants[nacks] = 1'b1; nacks++; end
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
`ifdef SRAM_ARB_CPU_PRIORITY_EN
        exp_grants = 4'b0000;
`else
        exp_grants = 4'b1010;
`endif
        check("rr_nacks", 32'(nacks), 32'd4);
        check("rr_grants", 32'(grants), 32'(exp_grants));
        cyc();
        check("rr_idle_busy", 32'(busy), 32'd0);

        // 5. reset during 2nd ACCESS cycle
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 16'h0777;
        Mem_DQ_in = 16'hDEAD;
        cyc();
        check("ra_c1_busy", 32'(busy), 32'd1);
        cyc();
        check("ra_c2_oe", 32'(Mem_OE), 32'd0);
        Reset = 1'b0;
        bus.p0_req = 1'b0;
        cyc();
        Reset = 1'b1;
        check("ra_busy", 32'(busy), 32'd0);
        check("ra_strobes", 32'(strobes()), 32'h1F);
        check("ra_p0_rdata", 32'(bus.p0_rdata), 32'd0);
        ack0 = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.p0_ack || bus.p1_ack) ack0++;
        end
        check("ra_no_ack", 32'(ack0), 32'd0);

        // 6. p0 drops req in 1st ACCESS cycle
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 16'h0042;
        Mem_DQ_in = 16'h5A5A;
        cyc();
        check("dr_c1_busy", 32'(busy), 32'd1);
        bus.p0_req = 1'b0; bus.p0_addr = 16'hFFFF;
        cyc();
        check("dr_c2_oe", 32'(Mem_OE), 32'd0);
        check("dr_c2_addr", 32'(Mem_ADDR), 32'h00042);
        cyc();
        check("dr_c3_ack", 32'(bus.p0_ack), 32'd1);
        check("dr_c3_rdata", 32'(bus.p0_rdata), 32'h5A5A);
        cyc();
        check("dr_c4_busy", 32'(busy), 32'd0);
        cyc();
        check("dr_c5_busy", 32'(busy), 32'd0);
        check("dr_c5_addr", 32'(Mem_ADDR), 32'h00042);

        // sanity bound: arbiter must settle idle
        waited = 0;
        while (busy && waited < 10) begin cyc(); waited++; end
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
